// File: rtl/riscv_alu_arbiter.sv
// Two-port round-robin arbiter in front of one shared combinational ALU.
// Each port owns a one-entry response register with valid/ready handshake.
module riscv_alu_arbiter #(
    parameter int XLEN  = 64,
    parameter int CTRLW = 6
) (
    input  logic             i_riscv_alu_arb_clk,
    input  logic             i_riscv_alu_arb_rst_n,

    input  logic             i_riscv_alu_arb_req0_valid,
    output logic             o_riscv_alu_arb_req0_ready,
    input  logic [CTRLW-1:0] i_riscv_alu_arb_req0_ctrl,
    input  logic [XLEN-1:0]  i_riscv_alu_arb_req0_rs1,
    input  logic [XLEN-1:0]  i_riscv_alu_arb_req0_rs2,

    input  logic             i_riscv_alu_arb_req1_valid,
    output logic             o_riscv_alu_arb_req1_ready,
    input  logic [CTRLW-1:0] i_riscv_alu_arb_req1_ctrl,
    input  logic [XLEN-1:0]  i_riscv_alu_arb_req1_rs1,
    input  logic [XLEN-1:0]  i_riscv_alu_arb_req1_rs2,

    output logic             o_riscv_alu_arb_rsp0_valid,
    input  logic             i_riscv_alu_arb_rsp0_ready,
    output logic [XLEN-1:0]  o_riscv_alu_arb_rsp0_result,

    output logic             o_riscv_alu_arb_rsp1_valid,
    input  logic             i_riscv_alu_arb_rsp1_ready,
    output logic [XLEN-1:0]  o_riscv_alu_arb_rsp1_result,

    output logic [CTRLW-1:0] o_riscv_alu_arb_alu_ctrl,
    output logic [XLEN-1:0]  o_riscv_alu_arb_alu_rs1data,
    output logic [XLEN-1:0]  o_riscv_alu_arb_alu_rs2data,
    input  logic [XLEN-1:0]  i_riscv_alu_arb_alu_result,

    output logic             o_riscv_alu_arb_grant_ptr
);

    logic            elig0_p0;
    logic            elig1_p0;
    logic            grant0_p0;
    logic            grant1_p0;

    logic            rsp0_vld_p1;
    logic            rsp1_vld_p1;
    logic [XLEN-1:0] rsp0_result_p1;
    logic [XLEN-1:0] rsp1_result_p1;
    logic            grant_ptr;

    // Stage p0: eligibility, grant and ALU drive (all combinational)
    always_comb begin
        elig0_p0  = i_riscv_alu_arb_req0_valid && (!rsp0_vld_p1 || i_riscv_alu_arb_rsp0_ready);
        elig1_p0  = i_riscv_alu_arb_req1_valid && (!rsp1_vld_p1 || i_riscv_alu_arb_rsp1_ready);
        grant0_p0 = elig0_p0 && (!elig1_p0 || grant_ptr);
        grant1_p0 = elig1_p0 && (!elig0_p0 || !grant_ptr);
    end

    always_comb begin
        o_riscv_alu_arb_alu_ctrl    = '0;
        o_riscv_alu_arb_alu_rs1data = '0;
        o_riscv_alu_arb_alu_rs2data = '0;
        if (grant0_p0) begin
            o_riscv_alu_arb_alu_ctrl    = i_riscv_alu_arb_req0_ctrl;
            o_riscv_alu_arb_alu_rs1data = i_riscv_alu_arb_req0_rs1;
            o_riscv_alu_arb_alu_rs2data = i_riscv_alu_arb_req0_rs2;
        end else if (grant1_p0) begin
            o_riscv_alu_arb_alu_ctrl    = i_riscv_alu_arb_req1_ctrl;
            o_riscv_alu_arb_alu_rs1data = i_riscv_alu_arb_req1_rs1;
            o_riscv_alu_arb_alu_rs2data = i_riscv_alu_arb_req1_rs2;
        end
    end

    assign o_riscv_alu_arb_req0_ready = grant0_p0;
    assign o_riscv_alu_arb_req1_ready = grant1_p0;

    // Stage p1: response registers; a regrant wins over a drain so there is no bubble
    always_ff @(posedge i_riscv_alu_arb_clk or negedge i_riscv_alu_arb_rst_n) begin
        if (!i_riscv_alu_arb_rst_n) begin
            rsp0_vld_p1    <= 1'b0;
            rsp1_vld_p1    <= 1'b0;
            rsp0_result_p1 <= '0;
            rsp1_result_p1 <= '0;
            grant_ptr      <= 1'b1;
        end else begin
            if (grant0_p0) begin
                rsp0_result_p1 <= i_riscv_alu_arb_alu_result;
                rsp0_vld_p1    <= 1'b1;
            end else if (rsp0_vld_p1 && i_riscv_alu_arb_rsp0_ready) begin
                rsp0_vld_p1    <= 1'b0;
            end

            if (grant1_p0) begin
                rsp1_result_p1 <= i_riscv_alu_arb_alu_result;
                rsp1_vld_p1    <= 1'b1;
            end else if (rsp1_vld_p1 && i_riscv_alu_arb_rsp1_ready) begin
                rsp1_vld_p1    <= 1'b0;
            end

            if (grant0_p0) begin
                grant_ptr <= 1'b0;
            end else if (grant1_p0) begin
                grant_ptr <= 1'b1;
            end
        end
    end

    assign o_riscv_alu_arb_rsp0_valid  = rsp0_vld_p1;
    assign o_riscv_alu_arb_rsp1_valid  = rsp1_vld_p1;
    assign o_riscv_alu_arb_rsp0_result = rsp0_result_p1;
    assign o_riscv_alu_arb_rsp1_result = rsp1_result_p1;
    assign o_riscv_alu_arb_grant_ptr   = grant_ptr;

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Bench for riscv_alu_arbiter: directed scenarios plus random traffic, checked by a
// queue scoreboard fed on acceptance and drained by an independent monitor.
module tb_riscv_alu_arbiter;

    localparam int XLEN  = 64;
    localparam int CTRLW = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [CTRLW-1:0] req0_ctrl = '0, req1_ctrl = '0;
    logic [XLEN-1:0]  req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [XLEN-1:0]  rsp0_result, rsp1_result;
    logic [CTRLW-1:0] alu_ctrl;
    logic [XLEN-1:0]  alu_rs1, alu_rs2, alu_result;
    logic             grant_ptr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] q0[$];
    logic [XLEN-1:0] q1[$];
    bit              last_win = 1'b1;
    bit              exp_g0 = 1'b0, exp_g1 = 1'b0;

    always #5 clk = ~clk;

    riscv_alu_arbiter #(.XLEN(XLEN), .CTRLW(CTRLW)) dut (
        .i_riscv_alu_arb_clk        (clk),
        .i_riscv_alu_arb_rst_n      (rst_n),
        .i_riscv_alu_arb_req0_valid (req0_valid),
        .o_riscv_alu_arb_req0_ready (req0_ready),
        .i_riscv_alu_arb_req0_ctrl  (req0_ctrl),
        .i_riscv_alu_arb_req0_rs1   (req0_rs1),
        .i_riscv_alu_arb_req0_rs2   (req0_rs2),
        .i_riscv_alu_arb_req1_valid (req1_valid),
        .o_riscv_alu_arb_req1_ready (req1_ready),
        .i_riscv_alu_arb_req1_ctrl  (req1_ctrl),
        .i_riscv_alu_arb_req1_rs1   (req1_rs1),
        .i_riscv_alu_arb_req1_rs2   (req1_rs2),
        .o_riscv_alu_arb_rsp0_valid (rsp0_valid),
        .i_riscv_alu_arb_rsp0_ready (rsp0_ready),
        .o_riscv_alu_arb_rsp0_result(rsp0_result),
        .o_riscv_alu_arb_rsp1_valid (rsp1_valid),
        .i_riscv_alu_arb_rsp1_ready (rsp1_ready),
        .o_riscv_alu_arb_rsp1_result(rsp1_result),
        .o_riscv_alu_arb_alu_ctrl   (alu_ctrl),
        .o_riscv_alu_arb_alu_rs1data(alu_rs1),
        .o_riscv_alu_arb_alu_rs2data(alu_rs2),
        .i_riscv_alu_arb_alu_result (alu_result),
        .o_riscv_alu_arb_grant_ptr  (grant_ptr)
    );

    // Behavioural ALU: enable in bit 5; ADD, SUB, AND, ADDW; anything else gives 0
    function automatic logic [XLEN-1:0] alu_fn(logic [CTRLW-1:0] c, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        logic [31:0] w;
        if (!c[CTRLW-1]) return '0;
        case (c[4:0])
            5'b00000: return a + b;
            5'b00001: return a - b;
            5'b00010: return a & b;
            5'b10000: begin
                w = a[31:0] + b[31:0];
                return {{32{w[31]}}, w};
            end
            default:  return '0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_ctrl, alu_rs1, alu_rs2);

    task automatic check(string name, logic [XLEN-1:0] got, logic [XLEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: predicts grants from the round-robin rule, checks outputs, pops on drain
    always @(negedge clk) begin
        bit e0, e1, g0, g1;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            last_win = 1'b1;
            exp_g0   = 1'b0;
            exp_g1   = 1'b0;
        end else begin
            e0 = req0_valid && (q0.size() == 0 || rsp0_ready);
            e1 = req1_valid && (q1.size() == 0 || rsp1_ready);
            g0 = e0 && (!e1 || last_win == 1'b1);
            g1 = e1 && !g0;
            check("req0_ready", {63'd0, req0_ready}, {63'd0, g0});
            check("req1_ready", {63'd0, req1_ready}, {63'd0, g1});
            check("grant_ptr", {63'd0, grant_ptr}, {63'd0, last_win});
            if (g0) begin
                check("alu_ctrl", {58'd0, alu_ctrl}, {58'd0, req0_ctrl});
                check("alu_rs1", alu_rs1, req0_rs1);
                check("alu_rs2", alu_rs2, req0_rs2);
            end else if (g1) begin
                check("alu_ctrl", {58'd0, alu_ctrl}, {58'd0, req1_ctrl});
                check("alu_rs1", alu_rs1, req1_rs1);
                check("alu_rs2", alu_rs2, req1_rs2);
            end else begin
                check("alu_idle", {58'd0, alu_ctrl} | alu_rs1 | alu_rs2, '0);
            end
            check("rsp0_valid", {63'd0, rsp0_valid}, {63'd0, q0.size() != 0});
            check("rsp1_valid", {63'd0, rsp1_valid}, {63'd0, q1.size() != 0});
            if (q0.size() != 0) begin
                check("rsp0_result", rsp0_result, q0[0]);
                if (rsp0_ready) void'(q0.pop_front());
            end
            if (q1.size() != 0) begin
                check("rsp1_result", rsp1_result, q1[0]);
                if (rsp1_ready) void'(q1.pop_front());
            end
            exp_g0 = g0;
            exp_g1 = g1;
        end
    end

    // Acceptor: on each predicted grant, push the expected ALU answer for that request
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (exp_g0) begin
                q0.push_back(alu_fn(req0_ctrl, req0_rs1, req0_rs2));
                last_win = 1'b0;
            end else if (exp_g1) begin
                q1.push_back(alu_fn(req1_ctrl, req1_rs1, req1_rs2));
                last_win = 1'b1;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int p, logic v, logic [CTRLW-1:0] c, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        if (p == 0) begin
            req0_valid = v; req0_ctrl = c; req0_rs1 = a; req0_rs2 = b;
        end else begin
            req1_valid = v; req1_ctrl = c; req1_rs1 = a; req1_rs2 = b;
        end
    endtask

    localparam logic [CTRLW-1:0] OP_ADD  = 6'b100000;
    localparam logic [CTRLW-1:0] OP_SUB  = 6'b100001;
    localparam logic [CTRLW-1:0] OP_AND  = 6'b100010;
    localparam logic [CTRLW-1:0] OP_ADDW = 6'b110000;
    localparam logic [CTRLW-1:0] OP_OFF  = 6'b000000;
    localparam logic [CTRLW-1:0] OP_BAD  = 6'b111111;

    initial begin
        logic [CTRLW-1:0] ops[6];
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND;
        ops[3] = OP_ADDW; ops[4] = OP_OFF; ops[5] = OP_BAD;

        #12;
        check("reset_rsp0_valid", {63'd0, rsp0_valid}, '0);
        check("reset_rsp1_valid", {63'd0, rsp1_valid}, '0);
        check("reset_results", rsp0_result | rsp1_result, '0);
        check("reset_grant_ptr", {63'd0, grant_ptr}, 64'd1);
        cycle();
        rst_n = 1'b1;

        // Full contention, both slots draining: strict alternation from port 0
        for (int k = 0; k < 8; k++) begin
            cycle();
            set_req(0, 1'b1, OP_ADD, 64'(k), 64'd1);
            set_req(1, 1'b1, OP_SUB, 64'd100, 64'(k));
            #1;
            check("alt_ready0", {63'd0, req0_ready}, {63'd0, (k % 2) == 0});
            check("alt_ready1", {63'd0, req1_ready}, {63'd0, (k % 2) == 1});
        end

        cycle();
        set_req(0, 1'b1, OP_ADD, 64'd5, 64'd7);
        set_req(1, 1'b0, OP_OFF, '0, '0);
        #1;
        check("add_ready0", {63'd0, req0_ready}, 64'd1);
        cycle();
        req0_valid = 1'b0;
        rsp0_ready = 1'b0;
        #1;
        check("add_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
        check("add_result", rsp0_result, 64'd12);
        check("idle_alu_ctrl", {58'd0, alu_ctrl}, '0);

        // Port 0 stalled by its full slot; port 1 must still be served every cycle
        for (int j = 0; j < 4; j++) begin
            cycle();
            set_req(0, 1'b1, OP_ADD, 64'd1, 64'd1);
            set_req(1, 1'b1, OP_ADD, 64'(j), 64'd2);
            #1;
            check("stall_ready0", {63'd0, req0_ready}, '0);
            check("stall_ready1", {63'd0, req1_ready}, 64'd1);
            check("stall_hold", rsp0_result, 64'd12);
        end

        cycle();
        rsp0_ready = 1'b1;
        set_req(0, 1'b1, OP_SUB, 64'd10, 64'd3);
        #1;
        check("drain_ready0", {63'd0, req0_ready}, 64'd1);
        check("drain_ready1", {63'd0, req1_ready}, '0);
        cycle();
        req0_valid = 1'b0;
        set_req(1, 1'b1, OP_ADDW, 64'h7FFF_FFFF, 64'd1);
        #1;
        check("sub_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
        check("sub_result", rsp0_result, 64'd7);
        cycle();
        set_req(1, 1'b1, OP_OFF, 64'd5, 64'd9);
        #1;
        check("addw_result", rsp1_result, 64'hFFFF_FFFF_8000_0000);
        cycle();
        req1_valid = 1'b0;
        #1;
        check("off_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
        check("off_result", rsp1_result, '0);

        for (int r = 0; r < 400; r++) begin
            cycle();
            set_req(0, 1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 5)],
                    {$urandom, $urandom}, {$urandom, $urandom});
            set_req(1, 1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 5)],
                    {$urandom, $urandom}, {$urandom, $urandom});
            rsp0_ready = 1'($urandom_range(0, 9) < 7);
            rsp1_ready = 1'($urandom_range(0, 9) < 7);
        end

        cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        cycle();
        rsp0_ready = 1'b0;
        set_req(0, 1'b1, OP_ADD, 64'd2, 64'd3);
        cycle();
        req0_valid = 1'b0;
        #1;
        check("pre_reset_valid", {63'd0, rsp0_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rsp0_valid", {63'd0, rsp0_valid}, '0);
        check("async_rsp0_result", rsp0_result, '0);
        check("async_grant_ptr", {63'd0, grant_ptr}, 64'd1);
        cycle();
        cycle();
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        cycle();
        set_req(0, 1'b1, OP_ADD, 64'd4, 64'd4);
        set_req(1, 1'b1, OP_SUB, 64'd9, 64'd4);
        #1;
        check("tie_ready0", {63'd0, req0_ready}, 64'd1);
        check("tie_ready1", {63'd0, req1_ready}, '0);
        cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
